// File: rtl/vdp1_vram_arbiter.sv
// Shares the single VDP1 VRAM port between CPU accesses, 16-word command-table
// bursts and preemptible sprite-pattern bursts; owns every VRAM_* output.
module vdp1_vram_arbiter #(
  parameter int ADDR_W    = 18,
  parameter int CMD_WORDS = 16,
  parameter int PAT_LEN_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE_R,
  input  logic                 CPU_REQ,
  input  logic [ADDR_W-1:0]    CPU_A,
  input  logic [15:0]          CPU_D,
  input  logic [1:0]           CPU_WE,
  output logic                 CPU_ACK,
  output logic [15:0]          CPU_Q,
  input  logic                 CMD_REQ,
  input  logic [ADDR_W-1:0]    CMD_A,
  output logic                 CMD_VALID,
  output logic [$clog2(CMD_WORDS)-1:0] CMD_IDX,
  output logic [15:0]          CMD_Q,
  output logic                 CMD_DONE,
  input  logic                 PAT_REQ,
  input  logic [ADDR_W-1:0]    PAT_A,
  input  logic [PAT_LEN_W-1:0] PAT_LEN,
  output logic                 PAT_VALID,
  output logic [15:0]          PAT_Q,
  output logic                 PAT_DONE,
  output logic [ADDR_W-1:0]    VRAM_A,
  output logic [15:0]          VRAM_D,
  output logic [1:0]           VRAM_WE,
  output logic                 VRAM_RD,
  input  logic [15:0]          VRAM_Q,
  input  logic                 VRAM_RDY,
  output logic                 BUSY
);

  localparam int IDX_W = $clog2(CMD_WORDS);

  typedef enum logic [1:0] {IDLE, CPU_WAIT, CMD_WAIT, PAT_WAIT} state_e;

  state_e                 state_q,     state_d;
  logic [ADDR_W-1:0]      vram_a_q,    vram_a_d;
  logic [15:0]            vram_d_q,    vram_d_d;
  logic [1:0]             vram_we_q,   vram_we_d;
  logic                   vram_rd_q,   vram_rd_d;
  logic                   cpu_ack_q,   cpu_ack_d;
  logic [15:0]            cpu_q_q,     cpu_q_d;
  logic                   cpu_wr_q,    cpu_wr_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [IDX_W-1:0]       cmd_idx_q,   cmd_idx_d;
  logic [15:0]            cmd_q_q,     cmd_q_d;
  logic                   cmd_done_q,  cmd_done_d;
  logic [IDX_W-1:0]       cmd_cnt_q,   cmd_cnt_d;
  logic                   pat_valid_q, pat_valid_d;
  logic [15:0]            pat_q_q,     pat_q_d;
  logic                   pat_done_q,  pat_done_d;
  logic [PAT_LEN_W-1:0]   pat_rem_q,   pat_rem_d;
  logic [ADDR_W-1:0]      pat_addr_q,  pat_addr_d;
  logic                   pat_pend_q,  pat_pend_d;
  logic                   complete;

  // A VRAM_RDY seen while a strobe is still out belongs to the issue cycle.
  assign complete = VRAM_RDY && !vram_rd_q && (vram_we_q == 2'b00);

  always_comb begin
    // NOTE: every next-state value defaults to hold first, so no path through
    // the case below can leave a signal unassigned and infer a latch.
    state_d     = state_q;
    vram_a_d    = vram_a_q;
    vram_d_d    = vram_d_q;
    vram_we_d   = vram_we_q;
    vram_rd_d   = vram_rd_q;
    cpu_ack_d   = cpu_ack_q;
    cpu_q_d     = cpu_q_q;
    cpu_wr_d    = cpu_wr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_idx_d   = cmd_idx_q;
    cmd_q_d     = cmd_q_q;
    cmd_done_d  = cmd_done_q;
    cmd_cnt_d   = cmd_cnt_q;
    pat_valid_d = pat_valid_q;
    pat_q_d     = pat_q_q;
    pat_done_d  = pat_done_q;
    pat_rem_d   = pat_rem_q;
    pat_addr_d  = pat_addr_q;
    pat_pend_d  = pat_pend_q;

    if (CE_R) begin
      cpu_ack_d   = 1'b0;
      cmd_valid_d = 1'b0;
      cmd_done_d  = 1'b0;
      pat_valid_d = 1'b0;
      pat_done_d  = 1'b0;
      vram_rd_d   = 1'b0;
      vram_we_d   = 2'b00;

      unique case (state_q)
        IDLE: begin
          // Pulses still high mean the requester has not yet seen its ack.
          if (CPU_REQ && !cpu_ack_q) begin
            vram_a_d  = CPU_A;
            vram_d_d  = CPU_D;
            vram_we_d = CPU_WE;
            vram_rd_d = (CPU_WE == 2'b00);
            cpu_wr_d  = (CPU_WE != 2'b00);
            state_d   = CPU_WAIT;
          end else if (CMD_REQ && !cmd_done_q && !pat_pend_q) begin
            vram_a_d  = CMD_A;
            vram_rd_d = 1'b1;
            cmd_cnt_d = '0;
            state_d   = CMD_WAIT;
          end else if (PAT_REQ && !pat_done_q) begin
            vram_a_d  = pat_pend_q ? pat_addr_q : PAT_A;
            pat_rem_d = pat_pend_q ? pat_rem_q : PAT_LEN;
            vram_rd_d = 1'b1;
            state_d   = PAT_WAIT;
          end
        end

        CPU_WAIT: if (complete) begin
          if (!cpu_wr_q) cpu_q_d = VRAM_Q;
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end

        CMD_WAIT: if (complete) begin
          cmd_q_d     = VRAM_Q;
          cmd_idx_d   = cmd_cnt_q;
          cmd_valid_d = 1'b1;
          if (cmd_cnt_q == IDX_W'(CMD_WORDS - 1)) begin
            cmd_done_d = 1'b1;
            state_d    = IDLE;
          end else begin
            cmd_cnt_d = cmd_cnt_q + IDX_W'(1);
            vram_a_d  = vram_a_q + ADDR_W'(1);
            vram_rd_d = 1'b1;
          end
        end

        PAT_WAIT: if (complete) begin
          pat_q_d     = VRAM_Q;
          pat_valid_d = 1'b1;
          if (pat_rem_q == '0) begin
            pat_done_d = 1'b1;
            pat_pend_d = 1'b0;
            state_d    = IDLE;
          end else if (CPU_REQ) begin
            pat_addr_d = vram_a_q + ADDR_W'(1);
            pat_rem_d  = pat_rem_q - PAT_LEN_W'(1);
            pat_pend_d = 1'b1;
            state_d    = IDLE;
          end else begin
            pat_rem_d = pat_rem_q - PAT_LEN_W'(1);
            vram_a_d  = vram_a_q + ADDR_W'(1);
            vram_rd_d = 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      vram_a_q    <= '0;
      vram_d_q    <= '0;
      vram_we_q   <= '0;
      vram_rd_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_q_q     <= '0;
      cpu_wr_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= '0;
      cmd_q_q     <= '0;
      cmd_done_q  <= 1'b0;
      cmd_cnt_q   <= '0;
      pat_valid_q <= 1'b0;
      pat_q_q     <= '0;
      pat_done_q  <= 1'b0;
      pat_rem_q   <= '0;
      pat_addr_q  <= '0;
      pat_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vram_a_q    <= vram_a_d;
      vram_d_q    <= vram_d_d;
      vram_we_q   <= vram_we_d;
      vram_rd_q   <= vram_rd_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_q_q     <= cpu_q_d;
      cpu_wr_q    <= cpu_wr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_q_q     <= cmd_q_d;
      cmd_done_q  <= cmd_done_d;
      cmd_cnt_q   <= cmd_cnt_d;
      pat_valid_q <= pat_valid_d;
      pat_q_q     <= pat_q_d;
      pat_done_q  <= pat_done_d;
      pat_rem_q   <= pat_rem_d;
      pat_addr_q  <= pat_addr_d;
      pat_pend_q  <= pat_pend_d;
    end
  end

  assign VRAM_A    = vram_a_q;
  assign VRAM_D    = vram_d_q;
  assign VRAM_WE   = vram_we_q;
  assign VRAM_RD   = vram_rd_q;
  assign CPU_ACK   = cpu_ack_q;
  assign CPU_Q     = cpu_q_q;
  assign CMD_VALID = cmd_valid_q;
  assign CMD_IDX   = cmd_idx_q;
  assign CMD_Q     = cmd_q_q;
  assign CMD_DONE  = cmd_done_q;
  assign PAT_VALID = pat_valid_q;
  assign PAT_Q     = pat_q_q;
  assign PAT_DONE  = pat_done_q;
  assign BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_vdp1_vram_arbiter.sv
// Directed bench for vdp1_vram_arbiter: a latency-programmable VRAM responder,
// a negedge monitor logging strobes/pulses, and hand-derived expectations.
module tb_vdp1_vram_arbiter;

  logic        CLK = 1'b0;
  logic        RST, CE_R;
  logic        CPU_REQ, CMD_REQ, PAT_REQ;
  logic [17:0] CPU_A, CMD_A, PAT_A;
  logic [15:0] CPU_D;
  logic [1:0]  CPU_WE;
  logic [3:0]  PAT_LEN;
  logic        CPU_ACK, CMD_VALID, CMD_DONE, PAT_VALID, PAT_DONE;
  logic [15:0] CPU_Q, CMD_Q, PAT_Q;
  logic [3:0]  CMD_IDX;
  logic [17:0] VRAM_A;
  logic [15:0] VRAM_D, VRAM_Q;
  logic [1:0]  VRAM_WE;
  logic        VRAM_RD, VRAM_RDY, BUSY;

  vdp1_vram_arbiter dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R),
    .CPU_REQ(CPU_REQ), .CPU_A(CPU_A), .CPU_D(CPU_D), .CPU_WE(CPU_WE),
    .CPU_ACK(CPU_ACK), .CPU_Q(CPU_Q),
    .CMD_REQ(CMD_REQ), .CMD_A(CMD_A), .CMD_VALID(CMD_VALID), .CMD_IDX(CMD_IDX),
    .CMD_Q(CMD_Q), .CMD_DONE(CMD_DONE),
    .PAT_REQ(PAT_REQ), .PAT_A(PAT_A), .PAT_LEN(PAT_LEN), .PAT_VALID(PAT_VALID),
    .PAT_Q(PAT_Q), .PAT_DONE(PAT_DONE),
    .VRAM_A(VRAM_A), .VRAM_D(VRAM_D), .VRAM_WE(VRAM_WE), .VRAM_RD(VRAM_RD),
    .VRAM_Q(VRAM_Q), .VRAM_RDY(VRAM_RDY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vdat(input logic [17:0] a);
    return a[15:0] ^ 16'hC3A5 ^ {14'd0, a[17:16]};
  endfunction

  // Monitor logs
  logic [17:0] strobe_a[$];
  logic [1:0]  strobe_we[$];
  logic [15:0] strobe_d[$];
  logic [3:0]  cmd_idx_log[$];
  logic [15:0] cmd_q_log[$];
  logic [15:0] pat_q_log[$];
  int          order[$];
  int          ack_cnt, cmd_done_cnt, pat_done_cnt, pat_done_pos;
  logic [3:0]  cmd_done_idx;
  logic [15:0] ack_q;

  // Responder state
  int          lat = 1;
  int          resp_cnt = 0;
  logic [15:0] resp_data;

  task automatic clear_logs();
    strobe_a.delete(); strobe_we.delete(); strobe_d.delete();
    cmd_idx_log.delete(); cmd_q_log.delete(); pat_q_log.delete(); order.delete();
    ack_cnt = 0; cmd_done_cnt = 0; pat_done_cnt = 0; pat_done_pos = 0;
    cmd_done_idx = 4'd0; ack_q = 16'd0;
  endtask

  initial begin
    VRAM_RDY = 1'b0;
    VRAM_Q   = 16'd0;
    forever begin
      @(negedge CLK);
      if (VRAM_RD || VRAM_WE != 2'b00) begin
        strobe_a.push_back(VRAM_A);
        strobe_we.push_back(VRAM_WE);
        strobe_d.push_back(VRAM_D);
      end
      if (CPU_ACK) begin ack_cnt++; ack_q = CPU_Q; order.push_back(1); end
      if (CMD_VALID) begin cmd_idx_log.push_back(CMD_IDX); cmd_q_log.push_back(CMD_Q); end
      if (CMD_DONE) begin cmd_done_cnt++; cmd_done_idx = CMD_IDX; order.push_back(2); end
      if (PAT_VALID) pat_q_log.push_back(PAT_Q);
      if (PAT_DONE) begin pat_done_cnt++; pat_done_pos = pat_q_log.size(); order.push_back(3); end
      VRAM_RDY = 1'b0;
      if (RST) resp_cnt = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin VRAM_RDY = 1'b1; VRAM_Q = resp_data; end
      end
      if (!RST && (VRAM_RD || VRAM_WE != 2'b00)) begin
        resp_cnt  = lat;
        resp_data = VRAM_RD ? vdat(VRAM_A) : 16'hDEAD;
      end
    end
  end

  // One cycle; requesters drop REQ once they see their ack/done.
  task automatic step();
    @(negedge CLK);
    #1;
    if (CPU_ACK)  CPU_REQ = 1'b0;
    if (CMD_DONE) CMD_REQ = 1'b0;
    if (PAT_DONE) PAT_REQ = 1'b0;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input string tag);
    int i = 0;
    while ((CPU_REQ || CMD_REQ || PAT_REQ || BUSY) && i < 400) begin
      step();
      i++;
    end
    check({tag, "_timeout"}, 32'(i < 400), 32'd1);
    step_n(2);
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1;
    CPU_REQ = 1'b0; CMD_REQ = 1'b0; PAT_REQ = 1'b0;
    CPU_A = '0; CMD_A = '0; PAT_A = '0; CPU_D = '0; CPU_WE = '0; PAT_LEN = '0;
    clear_logs();
    step_n(2);
    check("rst_busy",  32'(BUSY),    32'd0);
    check("rst_rd",    32'(VRAM_RD), 32'd0);
    check("rst_we",    32'(VRAM_WE), 32'd0);
    check("rst_addr",  32'(VRAM_A),  32'd0);
    check("rst_ack",   32'(CPU_ACK), 32'd0);
    RST = 1'b0;
    step_n(2);

    // CPU write, VRAM ready three cycles after the strobe
    clear_logs();
    lat = 3;
    CPU_A = 18'h00010; CPU_D = 16'hBEEF; CPU_WE = 2'b11; CPU_REQ = 1'b1;
    step_n(2);
    check("wr_busy_mid", 32'(BUSY), 32'd1);
    run_until_idle("wr");
    check("wr_strobes", 32'(strobe_a.size()), 32'd1);
    if (strobe_a.size() >= 1) begin
      check("wr_addr", 32'(strobe_a[0]),  32'h10);
      check("wr_we",   32'(strobe_we[0]), 32'h3);
      check("wr_data", 32'(strobe_d[0]),  32'hBEEF);
    end
    check("wr_acks", 32'(ack_cnt), 32'd1);
    check("wr_busy_end", 32'(BUSY), 32'd0);

    // Full command-table burst
    clear_logs();
    lat = 1;
    CMD_A = 18'h00100; CMD_REQ = 1'b1;
    run_until_idle("cmd");
    check("cmd_strobes", 32'(strobe_a.size()), 32'd16);
    check("cmd_valids", 32'(cmd_idx_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < strobe_a.size()) begin
        check($sformatf("cmd_addr%0d", i), 32'(strobe_a[i]), 32'h100 + 32'(i));
        check($sformatf("cmd_rd%0d", i), 32'(strobe_we[i]), 32'd0);
      end
      if (i < cmd_idx_log.size()) begin
        check($sformatf("cmd_idx%0d", i), 32'(cmd_idx_log[i]), 32'(i));
        check($sformatf("cmd_q%0d", i), 32'(cmd_q_log[i]), 32'(vdat(18'h100 + 18'(i))));
      end
    end
    check("cmd_done_cnt", 32'(cmd_done_cnt), 32'd1);
    check("cmd_done_idx", 32'(cmd_done_idx), 32'd15);

    // CPU read raised mid-burst waits for CMD_DONE
    clear_logs();
    CMD_A = 18'h00200; CMD_REQ = 1'b1;
    begin
      int i = 0;
      while (!(CMD_VALID && CMD_IDX == 4'd3) && i < 200) begin step(); i++; end
      check("cpu_mid_cmd_wait", 32'(i < 200), 32'd1);
    end
    CPU_A = 18'h00055; CPU_WE = 2'b00; CPU_REQ = 1'b1;
    run_until_idle("cmdcpu");
    check("cmdcpu_strobes", 32'(strobe_a.size()), 32'd17);
    if (strobe_a.size() == 17) check("cmdcpu_last_addr", 32'(strobe_a[16]), 32'h55);
    check("cmdcpu_events", 32'(order.size()), 32'd2);
    if (order.size() == 2) begin
      check("cmdcpu_first", 32'(order[0]), 32'd2);
      check("cmdcpu_second", 32'(order[1]), 32'd1);
    end
    check("cmdcpu_cpu_q", 32'(ack_q), 32'(vdat(18'h00055)));

    // Pattern burst crossing the top of VRAM
    clear_logs();
    PAT_A = 18'h3FFFE; PAT_LEN = 4'd3; PAT_REQ = 1'b1;
    run_until_idle("wrap");
    check("wrap_strobes", 32'(strobe_a.size()), 32'd4);
    begin
      logic [17:0] exp_a [4];
      exp_a = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
      for (int i = 0; i < 4; i++) if (i < strobe_a.size())
        check($sformatf("wrap_addr%0d", i), 32'(strobe_a[i]), 32'(exp_a[i]));
      check("wrap_valids", 32'(pat_q_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) if (i < pat_q_log.size())
        check($sformatf("wrap_q%0d", i), 32'(pat_q_log[i]), 32'(vdat(exp_a[i])));
    end
    check("wrap_done_cnt", 32'(pat_done_cnt), 32'd1);
    check("wrap_done_pos", 32'(pat_done_pos), 32'd4);

    // Pattern burst preempted by a CPU write after word 2
    clear_logs();
    PAT_A = 18'h01000; PAT_LEN = 4'd7; PAT_REQ = 1'b1;
    begin
      int i = 0;
      while (!(PAT_VALID && PAT_Q == vdat(18'h01001)) && i < 200) begin step(); i++; end
      check("pre_wait", 32'(i < 200), 32'd1);
    end
    CPU_A = 18'h00077; CPU_D = 16'h1234; CPU_WE = 2'b01; CPU_REQ = 1'b1;
    PAT_A = 18'h2AAAA; PAT_LEN = 4'd1;
    run_until_idle("pre");
    begin
      logic [17:0] exp_a [9];
      exp_a = '{18'h01000, 18'h01001, 18'h01002, 18'h00077, 18'h01003,
                18'h01004, 18'h01005, 18'h01006, 18'h01007};
      check("pre_strobes", 32'(strobe_a.size()), 32'd9);
      for (int i = 0; i < 9; i++) if (i < strobe_a.size())
        check($sformatf("pre_addr%0d", i), 32'(strobe_a[i]), 32'(exp_a[i]));
      if (strobe_a.size() >= 4) begin
        check("pre_cpu_we", 32'(strobe_we[3]), 32'h1);
        check("pre_cpu_d",  32'(strobe_d[3]),  32'h1234);
      end
    end
    check("pre_valids", 32'(pat_q_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) if (i < pat_q_log.size())
      check($sformatf("pre_q%0d", i), 32'(pat_q_log[i]), 32'(vdat(18'h01000 + 18'(i))));
    check("pre_done_cnt", 32'(pat_done_cnt), 32'd1);
    check("pre_ack_cnt", 32'(ack_cnt), 32'd1);

    // Simultaneous requests, then reset in the middle of the CMD burst
    clear_logs();
    CPU_A = 18'h00033; CPU_WE = 2'b00; CPU_REQ = 1'b1;
    CMD_A = 18'h00300; CMD_REQ = 1'b1;
    PAT_A = 18'h00400; PAT_LEN = 4'd0; PAT_REQ = 1'b1;
    begin
      int i = 0;
      while (!(CMD_VALID && CMD_IDX == 4'd5) && i < 200) begin step(); i++; end
      check("sim_wait", 32'(i < 200), 32'd1);
    end
    check("sim_first_addr", 32'(strobe_a.size() > 0 ? strobe_a[0] : 18'h3FFFF), 32'h33);
    check("sim_second_addr", 32'(strobe_a.size() > 1 ? strobe_a[1] : 18'h3FFFF), 32'h300);
    check("sim_cpu_q", 32'(ack_q), 32'(vdat(18'h00033)));
    check("sim_no_pat", 32'(pat_q_log.size()), 32'd0);
    RST = 1'b1; CPU_REQ = 1'b0; CMD_REQ = 1'b0; PAT_REQ = 1'b0;
    step();
    check("mid_rst_busy",  32'(BUSY),      32'd0);
    check("mid_rst_rd",    32'(VRAM_RD),   32'd0);
    check("mid_rst_addr",  32'(VRAM_A),    32'd0);
    check("mid_rst_valid", 32'(CMD_VALID), 32'd0);
    check("mid_rst_idx",   32'(CMD_IDX),   32'd0);
    check("mid_rst_cmdq",  32'(CMD_Q),     32'd0);
    check("mid_rst_cpuq",  32'(CPU_Q),     32'd0);
    RST = 1'b0;
    step_n(6);
    check("mid_rst_no_done", 32'(cmd_done_cnt), 32'd0);
    check("mid_rst_idle",    32'(BUSY),         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
